// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard requests with
// memory-wait and mult/div occupancy. Optional counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic             jump,
  input  logic             md_start,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_ma_we,
  output logic             ma_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_ma_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned MD_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, MD_BUSY} state_t;

  state_t          state, state_nx;
  logic [MD_W-1:0] md_cnt, md_cnt_nx;

  logic mstall;
  logic md_last;
  logic pc_we_c, if_id_we_c, id_ex_we_c, ex_ma_we_c, ma_wb_we_c;
  logic if_id_flush_c, id_ex_flush_c, ex_ma_flush_c;

  assign mstall  = dmem_req & ~dmem_ready;
  assign md_last = (md_cnt == MD_W'(1));

  // State and mult/div down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nx;
      md_cnt <= md_cnt_nx;
    end
  end

  // Next state and per-stage enables/flushes
  always_comb begin
    state_nx      = state;
    md_cnt_nx     = md_cnt;
    pc_we_c       = 1'b0;
    if_id_we_c    = 1'b0;
    id_ex_we_c    = 1'b0;
    ex_ma_we_c    = 1'b0;
    ma_wb_we_c    = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    ex_ma_flush_c = 1'b0;
    case (state)
      RUN: begin
        if (mstall) begin
          state_nx = MEM_WAIT;
        end else if (md_start) begin
          ex_ma_we_c    = 1'b1;
          ex_ma_flush_c = 1'b1;
          ma_wb_we_c    = 1'b1;
          md_cnt_nx     = MD_W'(MD_CYCLES - 1);
          state_nx      = MD_BUSY;
        end else begin
          pc_we_c    = 1'b1;
          if_id_we_c = 1'b1;
          id_ex_we_c = 1'b1;
          ex_ma_we_c = 1'b1;
          ma_wb_we_c = 1'b1;
          if (br_taken | jump) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (load_use) begin
            pc_we_c       = 1'b0;
            if_id_we_c    = 1'b0;
            id_ex_flush_c = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          ma_wb_we_c = 1'b1;
          state_nx   = RUN;
        end
      end
      MD_BUSY: begin
        // Last cycle lets the result through; a memory stall holds it at count 1
        ex_ma_flush_c = ~md_last;
        if (mstall) begin
          md_cnt_nx = md_last ? md_cnt : md_cnt - MD_W'(1);
        end else begin
          ex_ma_we_c = 1'b1;
          ma_wb_we_c = 1'b1;
          md_cnt_nx  = md_cnt - MD_W'(1);
          if (md_last) state_nx = RUN;
        end
      end
      default: begin
        state_nx  = RUN;
        md_cnt_nx = '0;
      end
    endcase
  end

  // Everything reads as zero while reset is held
  assign pc_we       = rst_n & pc_we_c;
  assign if_id_we    = rst_n & if_id_we_c;
  assign id_ex_we    = rst_n & id_ex_we_c;
  assign ex_ma_we    = rst_n & ex_ma_we_c;
  assign ma_wb_we    = rst_n & ma_wb_we_c;
  assign if_id_flush = rst_n & if_id_flush_c;
  assign id_ex_flush = rst_n & id_ex_flush_c;
  assign ex_ma_flush = rst_n & ex_ma_flush_c;
  assign md_busy     = rst_n & (state == MD_BUSY);
  assign md_done     = rst_n & (state == MD_BUSY) & md_last;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             flush_evt;

  // Only a branch/jump raises the IF/ID flush
  assign flush_evt = if_id_flush_c;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we_c && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MD_CYCLES=4, CNT_W=4); counter checks expect
// zeros unless PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  localparam int unsigned CW = 4;

  // {pc, if_id, id_ex, ex_ma, ma_wb, if_id_fl, id_ex_fl, ex_ma_fl, busy, done}
  localparam logic [9:0] V_ZERO   = 10'b00000_000_00;
  localparam logic [9:0] V_NORM   = 10'b11111_000_00;
  localparam logic [9:0] V_LDUSE  = 10'b00111_010_00;
  localparam logic [9:0] V_FLUSH  = 10'b11111_110_00;
  localparam logic [9:0] V_MDST   = 10'b00011_001_00;
  localparam logic [9:0] V_MDBSY  = 10'b00011_001_10;
  localparam logic [9:0] V_MDDONE = 10'b00011_000_11;
  localparam logic [9:0] V_MDBSTL = 10'b00000_001_10;
  localparam logic [9:0] V_MDDSTL = 10'b00000_000_11;
  localparam logic [9:0] V_MEMDN  = 10'b00001_000_00;

  logic clk = 1'b0;
  logic rst_n;
  logic load_use, br_taken, jump, md_start, dmem_req, dmem_ready;
  logic pc_we, if_id_we, id_ex_we, ex_ma_we, ma_wb_we;
  logic if_id_flush, id_ex_flush, ex_ma_flush, md_busy, md_done;
  logic [CW-1:0] stall_cycles, flush_events;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MD_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use(load_use), .br_taken(br_taken), .jump(jump),
    .md_start(md_start), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_ma_we(ex_ma_we), .ma_wb_we(ma_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_ma_flush(ex_ma_flush),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  function automatic logic [9:0] outv();
    return {pc_we, if_id_we, id_ex_we, ex_ma_we, ma_wb_we,
            if_id_flush, id_ex_flush, ex_ma_flush, md_busy, md_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sampled at the falling edge, mid-cycle
  task automatic chk_out(input string tag, input logic [9:0] exp);
    @(negedge clk);
    chk(tag, 32'(outv()), 32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int st, input int fl);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(st));
    chk({tag, "_flush"}, 32'(flush_events), 32'(fl));
`else
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(st * 0));
    chk({tag, "_flush"}, 32'(flush_events), 32'(fl * 0));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_use = 0; br_taken = 0; jump = 0; md_start = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      {load_use, br_taken, jump, md_start, dmem_req, dmem_ready} = 6'($urandom);
      chk_out("rst_outs", V_ZERO);
      chk_cnt("rst_cnt", 0, 0);
      tick();
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_out("idle_run", V_NORM);
    tick();

    // Load-use for one cycle
    load_use = 1;
    chk_out("ld_use", V_LDUSE);
    tick(); idle();
    chk_out("ld_use_after", V_NORM);
    tick();

    // Branch beats load-use, then a jump
    br_taken = 1; load_use = 1;
    chk_out("br_ld", V_FLUSH);
    tick(); idle(); jump = 1;
    chk_out("jump", V_FLUSH);
    tick(); idle();
    chk_out("br_after", V_NORM);
    chk_cnt("after_br", 1, 2);
    tick();

    // Mult/div, md_start held into the busy phase must be ignored
    md_start = 1;
    chk_out("md_c1", V_MDST);
    tick();
    chk_out("md_c2", V_MDBSY);
    tick(); idle();
    chk_out("md_c3", V_MDBSY);
    tick();
    chk_out("md_c4_done", V_MDDONE);
    tick();
    chk_out("md_back_run", V_NORM);
    chk_cnt("after_md", 5, 2);
    tick();

    // Memory stall 3 cycles then ready; branch during wait is ignored
    dmem_req = 1;
    chk_out("mem_f1", V_ZERO);
    tick(); br_taken = 1;
    chk_out("mem_f2", V_ZERO);
    tick();
    chk_out("mem_f3", V_ZERO);
    tick(); br_taken = 0; dmem_ready = 1;
    chk_out("mem_done", V_MEMDN);
    tick(); idle();
    chk_out("mem_back_run", V_NORM);
    chk_cnt("after_mem", 9, 2);
    tick();

    // Mult/div interleaved with memory stalls, incl. held md_done
    md_start = 1;
    chk_out("mdm_c1", V_MDST);
    tick(); idle(); dmem_req = 1;
    chk_out("mdm_stall_cnt3", V_MDBSTL);
    tick(); dmem_req = 0;
    chk_out("mdm_cnt2", V_MDBSY);
    tick(); dmem_req = 1;
    chk_out("mdm_done_stall1", V_MDDSTL);
    tick();
    chk_out("mdm_done_stall2", V_MDDSTL);
    tick(); dmem_req = 0;
    chk_out("mdm_done", V_MDDONE);
    tick();
    chk_out("mdm_back_run", V_NORM);
    chk_cnt("after_mdm", 15, 2);
    tick();

    // Reset mid mult/div aborts with no md_done
    md_start = 1;
    tick(); idle();
    chk_out("mdr_busy", V_MDBSY);
    rst_n = 1'b0;
    #1 chk("mdr_rst_outs", 32'(outv()), 32'(V_ZERO));
    chk_cnt("mdr_rst_cnt", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_out("mdr_after", V_NORM);
    tick();

    // Reset mid memory wait
    dmem_req = 1;
    tick();
    chk_out("memr_wait", V_ZERO);
    rst_n = 1'b0;
    dmem_ready = 1;
    tick();
    chk_out("memr_rst", V_ZERO);
    idle();
    rst_n = 1'b1;
    tick();
    chk_out("memr_after", V_NORM);
    chk_cnt("memr_cnt", 0, 0);
    tick();

    // Hold load-use for 20 cycles: stall counter saturates at 15
    load_use = 1;
    for (int i = 0; i < 14; i++) tick();
    chk_out("sat_ld_use", V_LDUSE);
    chk_cnt("sat_14", 14, 0);
    for (int i = 14; i < 20; i++) tick();
    idle();
    chk_out("sat_after", V_NORM);
    chk_cnt("sat_15", 15, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MA, WB). It merges the combinational hazard requests (load-use, taken branch, jump) with multi-cycle events (data-memory wait, iterative mult/div in EX). From these it drives the PC and every pipeline-register write enable and flush. It sits beside the hazard detector: the hazard detector reports conditions, and `pipe_ctrl` decides and sequences the per-stage response.

## Interface
Parameters:
- `MD_CYCLES`, default 32: EX occupancy of a mult/div op, in cycles (≥2).
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_use`  in  1  load in EX, and ID reads its rt.
- `br_taken`  in  1  branch in EX resolved taken.
- `jump`  in  1  jump in EX.
- `md_start`  in  1  mult/div in EX, first cycle only.
- `dmem_req`  in  1  MA stage accessing data memory.
- `dmem_ready`  in  1  data memory completes this cycle.
- `pc_we`  out  1  PC write enable.
- `if_id_we`, `id_ex_we`, `ex_ma_we`, `ma_wb_we`  out  1 each  pipeline register write enables.
- `if_id_flush`, `id_ex_flush`, `ex_ma_flush`  out  1 each  load a bubble (NOP, control bits 0) into that register.
- `md_busy`  out  1  mult/div unit occupied.
- `md_done`  out  1  one-cycle pulse on the last mult/div cycle.
- `stall_cycles`  out  CNT_W  performance counter (see Configuration).
- `flush_events`  out  CNT_W  performance counter (see Configuration).

## Operation
- State machine: `RUN`, `MEM_WAIT`, `MD_BUSY`. The down-counter `md_cnt` is ceil(log2(MD_CYCLES)) bits wide.
- A memory stall is `mstall = dmem_req & ~dmem_ready`.
- `RUN`, evaluated in priority order:
  1. `mstall`: all `*_we`=0, `pc_we`=0, no flush. Next state `MEM_WAIT`.
  2. `md_start`: `pc_we`, `if_id_we`, `id_ex_we` = 0; `ex_ma_we`=1 with `ex_ma_flush`=1; `ma_wb_we`=1. Load `md_cnt`=MD_CYCLES-1. Next state `MD_BUSY`.
  3. `br_taken | jump`: all we=1, `if_id_flush`=`id_ex_flush`=1. Increment `flush_events`.
  4. `load_use`: `pc_we`=`if_id_we`=0, `id_ex_flush`=1, rest we=1.
  5. Otherwise all we=1, no flush.
- `MEM_WAIT`: full freeze (all we=0). On `dmem_ready`=1, the completion cycle enables only `ma_wb_we`; next state `RUN`. Hazard inputs are ignored because EX is frozen, and they are re-evaluated in `RUN`.
- `MD_BUSY`: freeze IF/ID/EX (`pc_we`, `if_id_we`, `id_ex_we` = 0) and keep inserting EX→MA bubbles (`ex_ma_we`=1, `ex_ma_flush`=1). `md_cnt` decrements every cycle.
  - If `mstall` occurs here: `ex_ma_we`=`ma_wb_we`=0 for that cycle; `md_cnt` still decrements.
  - At `md_cnt`==1: `md_done`=1 and `ex_ma_flush`=0, so the result enters MA. Next state `RUN`. If `mstall` is also active that cycle, stay in `MD_BUSY` with `md_cnt`=1 and hold `md_done` until `mstall` clears.
- `md_busy`=1 exactly while in `MD_BUSY`.
- `md_start` is ignored outside `RUN`.

## Timing
- While `rst_n`=0, asynchronously: state=`RUN`, `md_cnt`=0, counters=0, and every output=0, including all enables. On the first edge after release, enables follow the `RUN` rules.
- Enable and flush outputs are combinational from the registered state and the current inputs, valid in the same cycle; there are no registered outputs. `md_busy` and `md_done` decode from the registered state and `md_cnt`.
- Latencies:
  - Branch/jump flush: same cycle as the request.
  - Load-use: exactly 1 bubble when the request is held for one cycle.
  - Mult/div: `pc_we` low for exactly MD_CYCLES cycles, counting from the `md_start` cycle and absent `mstall`.
- `mstall` asserted for N cycles from `RUN` gives N freeze cycles plus 1 completion cycle.
- Reset asserted mid-`MD_BUSY` or mid-`MEM_WAIT` aborts immediately with no `md_done` pulse.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_we`=0 outside reset.
  - `flush_events` increments on every branch/jump flush.
  - Both saturate at 2^CNT_W-1 and never wrap.
- `PIPE_CTRL_PERF_EN` undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Reset held, inputs random → all outputs 0. After release with inputs idle → `pc_we`=all we=1, flushes 0.
- `load_use` for 1 cycle → that cycle `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1. Next cycle normal.
- `br_taken` and `load_use` together → `if_id_flush`=`id_ex_flush`=1, `pc_we`=1. `flush_events` +1 (PERF).
- `md_start` with MD_CYCLES=4 → `pc_we`=0 for 4 cycles. `md_done` on the 4th cycle with `ex_ma_flush`=0. Back to `RUN`.
- `dmem_req`=1, `dmem_ready`=0 for 3 cycles then 1 → 3 full-freeze cycles, then 1 cycle with only `ma_wb_we`=1. `stall_cycles`=4 (PERF).
- With CNT_W=4, hold `load_use` for 20 cycles → `stall_cycles` saturates at 15.
